// File: rtl/mul_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mul_pkg : shared types and constants for the multiplier datapath |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mul_pkg;

  localparam int unsigned W_DEFAULT = 8;

  // Encodings for the R1 source select; R2's mux has the opposite sense
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef struct packed {
    logic l_r1;
    logic l_r2;
    logic l_r3;
    logic l_r4;
    logic r_r3;
    logic dec_r1;
    logic sel_r1;
    logic sel_r2;
    logic s_r;
    logic r_r;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mul_dp_ctrl_chk.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mul_dp_ctrl_chk : flags illegal CU strobe combinations (1 cycle) |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mul_dp_ctrl_chk
  import mul_pkg::*;
(
  input  ctrl_t ctrl,
  input  logic  r1_zero,
  output logic  err_pulse
);

  always_comb begin
    err_pulse = (ctrl.s_r & ctrl.r_r)
              | (ctrl.l_r1 & ctrl.dec_r1)
              | (ctrl.dec_r1 & r1_zero)
              | (ctrl.r_r3 & ctrl.l_r3);
  end

  logic unused_ctrl;
  assign unused_ctrl = ^{ctrl.l_r2, ctrl.l_r4, ctrl.sel_r1, ctrl.sel_r2};

endmodule
`default_nettype wire

// File: rtl/mul_datapath.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mul_datapath : repeated-addition multiplier datapath (CU slave)  |
// | Optional macro MUL_DP_OVF_EN enables sticky accumulator overflow |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mul_datapath
  import mul_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  input  logic           L_R1,
  input  logic           L_R2,
  input  logic           L_R3,
  input  logic           L_R4,
  input  logic           R_R3,
  input  logic           Dec_R1,
  input  logic           Sel_R1,
  input  logic           Sel_R2,
  input  logic           S_R,
  input  logic           R_R,
  output logic           OR_R1,
  output logic           CMP_L_R1,
  output logic [2*W-1:0] result,
  output logic           ready,
  output logic           ctrl_err,
  output logic           ovf
);

  ctrl_t          ctrl;
  logic [W-1:0]   r1_q, r1_d;
  logic [W-1:0]   r2_q, r2_d;
  logic [2*W-1:0] r3_q, r3_d;
  logic [2*W-1:0] r4_q, r4_d;
  logic           ready_q, ready_d;
  logic           ctrl_err_q, ctrl_err_d;
  logic           r1_zero;
  logic           err_pulse;
  logic [2*W-1:0] acc_sum;

  assign ctrl = '{l_r1: L_R1, l_r2: L_R2, l_r3: L_R3, l_r4: L_R4, r_r3: R_R3,
                  dec_r1: Dec_R1, sel_r1: Sel_R1, sel_r2: Sel_R2, s_r: S_R, r_r: R_R};
  assign r1_zero = (r1_q == '0);

  mul_dp_ctrl_chk u_ctrl_chk (
    .ctrl      (ctrl),
    .r1_zero   (r1_zero),
    .err_pulse (err_pulse)
  );

`ifdef MUL_DP_OVF_EN
  logic [2*W:0] acc_wide;
  logic         ovf_q, ovf_d;
  assign acc_wide = {1'b0, r3_q} + {{(W+1){1'b0}}, r2_q};
  assign acc_sum  = acc_wide[2*W-1:0];

  // Clear wins over a same-cycle carry, matching R3's own priority
  always_comb begin
    ovf_d = ovf_q;
    if (ctrl.r_r3)
      ovf_d = 1'b0;
    else if (ctrl.l_r3 && acc_wide[2*W])
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign acc_sum = r3_q + {{W{1'b0}}, r2_q};
  assign ovf     = 1'b0;
`endif

  always_comb begin
    r1_d = r1_q;
    if (ctrl.l_r1)
      r1_d = (ctrl.sel_r1 == SEL_B) ? b_in : a_in;
    else if (ctrl.dec_r1 && !r1_zero)
      r1_d = r1_q - W'(1);

    // R2's mux is wired the other way round: 0 picks b_in
    r2_d = r2_q;
    if (ctrl.l_r2)
      r2_d = (ctrl.sel_r2 == SEL_A) ? b_in : a_in;

    r3_d = r3_q;
    if (ctrl.r_r3)
      r3_d = '0;
    else if (ctrl.l_r3)
      r3_d = acc_sum;

    r4_d = ctrl.l_r4 ? r3_q : r4_q;

    ready_d = ready_q;
    if (ctrl.s_r && !ctrl.r_r)
      ready_d = 1'b1;
    else if (ctrl.r_r && !ctrl.s_r)
      ready_d = 1'b0;

    ctrl_err_d = ctrl_err_q | err_pulse;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_q       <= '0;
      r2_q       <= '0;
      r3_q       <= '0;
      r4_q       <= '0;
      ready_q    <= 1'b0;
      ctrl_err_q <= 1'b0;
    end else begin
      r1_q       <= r1_d;
      r2_q       <= r2_d;
      r3_q       <= r3_d;
      r4_q       <= r4_d;
      ready_q    <= ready_d;
      ctrl_err_q <= ctrl_err_d;
    end
  end

  assign OR_R1    = |r1_q;
  assign CMP_L_R1 = (a_in < b_in);
  assign result   = r4_q;
  assign ready    = ready_q;
  assign ctrl_err = ctrl_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_datapath.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mul_datapath : scoreboard bench for mul_datapath (W=8)        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_mul_datapath;

  localparam int W = 8;
`ifdef MUL_DP_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   a_in, b_in;
  logic           L_R1, L_R2, L_R3, L_R4, R_R3, Dec_R1, Sel_R1, Sel_R2, S_R, R_R;
  logic           OR_R1, CMP_L_R1, ready, ctrl_err, ovf;
  logic [2*W-1:0] result;

  typedef struct {
    string          name;
    logic [2*W-1:0] res;
    logic           orr;
    logic           rdy;
    logic           err;
    logic           ov;
    logic           cmp;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mul_datapath #(.W(W)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
    .L_R1(L_R1), .L_R2(L_R2), .L_R3(L_R3), .L_R4(L_R4), .R_R3(R_R3),
    .Dec_R1(Dec_R1), .Sel_R1(Sel_R1), .Sel_R2(Sel_R2), .S_R(S_R), .R_R(R_R),
    .OR_R1(OR_R1), .CMP_L_R1(CMP_L_R1), .result(result), .ready(ready),
    .ctrl_err(ctrl_err), .ovf(ovf)
  );

  // One clock edge with the currently driven strobes, then drop them all
  task automatic tick();
    @(posedge clk);
    #1;
    {rst, L_R1, L_R2, L_R3, L_R4, R_R3, Dec_R1, Sel_R1, Sel_R2, S_R, R_R} = '0;
  endtask

  task automatic expect_now(input string n, input logic [2*W-1:0] res, input logic orr,
                            input logic rdy, input logic err, input logic ov, input logic cmp);
    exp_t e;
    e.name = n; e.res = res; e.orr = orr; e.rdy = rdy; e.err = err; e.ov = ov; e.cmp = cmp;
    q.push_back(e);
  endtask

  // Monitor: drain every pending expectation on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (result !== e.res || OR_R1 !== e.orr || ready !== e.rdy ||
            ctrl_err !== e.err || ovf !== e.ov || CMP_L_R1 !== e.cmp) begin
          failures++;
          $display("FAIL %s: got result=%0d or=%b ready=%b err=%b ovf=%b cmp=%b, want result=%0d or=%b ready=%b err=%b ovf=%b cmp=%b",
                   e.name, result, OR_R1, ready, ctrl_err, ovf, CMP_L_R1,
                   e.res, e.orr, e.rdy, e.err, e.ov, e.cmp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    {L_R1, L_R2, L_R3, L_R4, R_R3, Dec_R1, Sel_R1, Sel_R2, S_R, R_R} = '0;
    a_in = '0; b_in = '0;
    rst = 1'b1; tick();
    rst = 1'b1; tick();
    expect_now("reset", 16'd0, 0, 0, 0, 0, 0);

    // 5 * 3 by repeated addition
    a_in = 8'd5; b_in = 8'd3;
    L_R1 = 1; Sel_R1 = 1; L_R2 = 1; Sel_R2 = 1; R_R3 = 1; tick();
    expect_now("mul_load", 16'd0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      L_R3 = 1; Dec_R1 = 1; tick();
    end
    L_R4 = 1; tick();
    S_R = 1; tick();
    expect_now("mul_5x3", 16'd15, 0, 1, 0, 0, 0);

    // Decrement at zero
    Dec_R1 = 1; tick();
    expect_now("dec_at_zero", 16'd15, 0, 1, 1, 0, 0);
    tick();
    expect_now("err_sticky", 16'd15, 0, 1, 1, 0, 0);

    // Set and clear ready together, then clear alone
    S_R = 1; R_R = 1; tick();
    expect_now("sr_rr_both", 16'd15, 0, 1, 1, 0, 0);
    R_R = 1; tick();
    expect_now("rr_alone", 16'd15, 0, 0, 1, 0, 0);

    // Reset in the middle of accumulation
    rst = 1; tick();
    expect_now("rst_clears_err", 16'd0, 0, 0, 0, 0, 0);
    L_R1 = 1; Sel_R1 = 0; L_R2 = 1; Sel_R2 = 1; R_R3 = 1; tick();
    L_R3 = 1; tick();
    L_R3 = 1; tick();
    L_R4 = 1; S_R = 1; tick();
    expect_now("acc_to_10", 16'd10, 1, 1, 0, 0, 0);
    rst = 1; tick();
    expect_now("rst_mid_op", 16'd0, 0, 0, 0, 0, 0);
    L_R4 = 1; tick();
    expect_now("rst_cleared_r3", 16'd0, 0, 0, 0, 0, 0);
    L_R3 = 1; tick();
    L_R4 = 1; tick();
    expect_now("rst_cleared_r2", 16'd0, 0, 0, 0, 0, 0);

    // Load and decrement together: load wins, error flagged
    L_R1 = 1; Sel_R1 = 0; Dec_R1 = 1; tick();
    expect_now("load_dec_both", 16'd0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      Dec_R1 = 1; tick();
    end
    expect_now("r1_at_one", 16'd0, 1, 0, 1, 0, 0);
    Dec_R1 = 1; tick();
    expect_now("r1_to_zero", 16'd0, 0, 0, 1, 0, 0);

    // Clear and accumulate together: clear wins
    rst = 1; tick();
    L_R2 = 1; Sel_R2 = 1; tick();
    L_R3 = 1; tick();
    R_R3 = 1; L_R3 = 1; tick();
    L_R4 = 1; tick();
    expect_now("clr_acc_both", 16'd0, 0, 0, 1, 0, 0);

    // Combinational compare and same-cycle capture
    rst = 1; tick();
    a_in = 8'd2; b_in = 8'd9;
    #1;
    expect_now("cmp_lt", 16'd0, 0, 0, 0, 0, 1);
    L_R2 = 1; Sel_R2 = 0; R_R3 = 1; tick();
    L_R3 = 1; tick();
    L_R3 = 1; L_R4 = 1; tick();
    expect_now("r4_old_r3", 16'd9, 0, 0, 0, 0, 1);
    L_R4 = 1; tick();
    expect_now("r4_new_r3", 16'd18, 0, 0, 0, 0, 1);

    // Accumulator wrap: 257*255 = 65535 fits, one more carries out
    rst = 1; tick();
    a_in = 8'd255; b_in = 8'd0;
    L_R2 = 1; Sel_R2 = 1; R_R3 = 1; tick();
    for (int i = 0; i < 257; i++) begin
      L_R3 = 1; tick();
    end
    L_R4 = 1; tick();
    expect_now("acc_max_no_ovf", 16'd65535, 0, 0, 0, 0, 0);
    L_R3 = 1; tick();
    L_R4 = 1; tick();
    expect_now("acc_wrap", 16'd254, 0, 0, 0, OVF_ON, 0);
    R_R3 = 1; tick();
    expect_now("ovf_cleared", 16'd254, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
